// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default line settings
// and the bit-period helper used by both the TX and RX sides.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ = 16_000_000;
    localparam int unsigned DEFAULT_BAUD     = 115_200;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_e;

    function automatic int unsigned uart_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo_tx.sv
// UART 8N1/8N2 transmitter that pops one byte per frame from the TX FIFO
// (one-cycle registered read latency) with optional cts_n flow control.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD      = DEFAULT_BAUD,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_data_ready,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    input  logic       cts_n,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST           = 1'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_fifo_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_fifo_tx: CLK_FREQ/BAUD must be at least 4");
    end

    tx_state_e        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic             stop_cnt, stop_cnt_next;
    logic [7:0]       shreg, shreg_next;
    logic             tx_next, busy_next, rd_next;
    logic             cts_meta, cts_s;
    logic             baud_wrap;

    assign baud_wrap = (cnt == CNT_MAX);

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            fifo_rd  <= 1'b0;
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
            shreg    <= shreg_next;
            tx       <= tx_next;
            busy     <= busy_next;
            fifo_rd  <= rd_next;
            cts_meta <= cts_n;
            cts_s    <= cts_meta;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        shreg_next    = shreg;

        case (state)
            IDLE: begin
                cnt_next      = '0;
                bit_idx_next  = '0;
                stop_cnt_next = 1'b0;
                if (fifo_data_ready && !cts_s) begin
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                shreg_next = fifo_data;
                state_next = START;
            end
            START: begin
                cnt_next = baud_wrap ? '0 : cnt + CNT_W'(1);
                if (baud_wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                cnt_next = baud_wrap ? '0 : cnt + CNT_W'(1);
                if (baud_wrap) begin
                    shreg_next = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_next = baud_wrap ? '0 : cnt + CNT_W'(1);
                if (baud_wrap) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs follow the state being entered so they stay registered
        rd_next   = (state_next == FETCH);
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx: behavioural FIFOs with 1-cycle read
// latency and an arithmetic frame model, for STOP_BITS=1 and STOP_BITS=2.
module tb_uart_fifo_tx;

    localparam int unsigned CF  = 16_000_000;
    localparam int unsigned BD  = 4_000_000;
    localparam int          CPB = CF / BD;

    logic clk;
    logic reset;
    logic cts1, cts2;
    logic rd1, tx1, busy1, rd2, tx2, busy2;
    logic fdr1, fdr2;
    logic [7:0] fd1, fd2;
    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
    int cyc = 0;
    int checks = 0, failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fdr1 = (wp1 != rp1);
    assign fdr2 = (wp2 != rp2);

    always @(posedge clk) begin
        if (rd1) begin
            fd1 <= mem1[rp1 % 64];
            rp1 <= rp1 + 1;
        end
        if (rd2) begin
            fd2 <= mem2[rp2 % 64];
            rp2 <= rp2 + 1;
        end
    end

    uart_fifo_tx #(.CLK_FREQ(CF), .BAUD(BD), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_data_ready(fdr1), .fifo_data(fd1),
        .fifo_rd(rd1), .cts_n(cts1), .tx(tx1), .busy(busy1)
    );

    uart_fifo_tx #(.CLK_FREQ(CF), .BAUD(BD), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .fifo_data_ready(fdr2), .fifo_data(fd2),
        .fifo_rd(rd2), .cts_n(cts2), .tx(tx2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wp1 % 64] = b;
        wp1 = wp1 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wp2 % 64] = b;
        wp2 = wp2 + 1;
    endtask

    function automatic logic tx_of(input int s);
        return (s == 2) ? tx2 : tx1;
    endfunction
    function automatic logic rd_of(input int s);
        return (s == 2) ? rd2 : rd1;
    endfunction
    function automatic logic busy_of(input int s);
        return (s == 2) ? busy2 : busy1;
    endfunction

    // Line level k cycles after the start-bit edge: start, 8 data LSB first, stop
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    task automatic wait_rd(input int s, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd_of(s)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic no_rd_for(input int s, input int n, input string tag);
        logic saw;
        saw = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rd_of(s)) saw = 1'b1;
        end
        chk(tag, saw, 1'b0);
    endtask

    task automatic expect_frame(input int s, input logic [7:0] b, input int stop_bits,
                                output int at);
        int flen;
        flen = (9 + stop_bits) * CPB;
        wait_rd(s, 300, at);
        if (at < 0) return;
        chk("fetch_busy", busy_of(s), 1'b1);
        chk("fetch_tx", tx_of(s), 1'b1);
        @(negedge clk);
        chk("load_rd", rd_of(s), 1'b0);
        chk("load_tx", tx_of(s), 1'b1);
        chk("load_busy", busy_of(s), 1'b1);
        for (int k = 0; k < flen; k++) begin
            @(negedge clk);
            chk("frame_tx", tx_of(s), frame_bit(b, k));
            chk("frame_busy", busy_of(s), 1'b1);
            chk("frame_rd", rd_of(s), 1'b0);
        end
        @(negedge clk);
        chk("idle_tx", tx_of(s), 1'b1);
        chk("idle_busy", busy_of(s), 1'b0);
    endtask

    initial begin
        int a, bb, rel, drop;
        logic [7:0] r [4];
        logic [7:0] f0, f1, g0, g1, h;

        reset = 1'b1;
        cts1  = 1'b0;
        cts2  = 1'b0;
        push1(8'hA5);

        // Reset held with a non-empty FIFO
        repeat (3) begin
            @(negedge clk);
            chk("reset_tx", tx1, 1'b1);
            chk("reset_busy", busy1, 1'b0);
            chk("reset_rd", rd1, 1'b0);
            chk("reset_tx2", tx2, 1'b1);
            chk("reset_busy2", busy2, 1'b0);
            chk("reset_rd2", rd2, 1'b0);
        end
        reset = 1'b0;
        rel = cyc;

        // Single byte 0xA5
        expect_frame(1, 8'hA5, 1, a);
        chk("pop_after_reset", 32'(a - rel), 32'd1);
        chk("single_pop_count", 32'(wp1 - rp1), 32'd0);
        no_rd_for(1, 20, "single_extra_pop");

        // Back-to-back 0x00 then 0xFF
        push1(8'h00);
        push1(8'hFF);
        expect_frame(1, 8'h00, 1, a);
        expect_frame(1, 8'hFF, 1, bb);
        chk("b2b_gap", 32'(bb - a), 32'd43);
        chk("b2b_empty", 32'(wp1 - rp1), 32'd0);
        no_rd_for(1, 50, "b2b_extra_pop");

        // Random back-to-back bytes
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'($urandom);
            push1(r[i]);
        end
        expect_frame(1, r[0], 1, a);
        for (int i = 1; i < 4; i++) begin
            expect_frame(1, r[i], 1, bb);
            chk("rand_gap", 32'(bb - a), 32'd43);
            a = bb;
        end
        chk("rand_empty", 32'(wp1 - rp1), 32'd0);

        // Flow control
        cts1 = 1'b1;
        repeat (4) @(negedge clk);
        f0 = 8'($urandom);
        f1 = 8'($urandom);
        push1(f0);
        push1(f1);
        no_rd_for(1, 100, "cts_hold");
        cts1 = 1'b0;
        drop = cyc;
        fork
            expect_frame(1, f0, 1, a);
            begin
                repeat (12) @(negedge clk);
                cts1 = 1'b1;
            end
        join
        chk("cts_latency", ((a - drop) >= 3 && (a - drop) <= 4), 1'b1);
        no_rd_for(1, 100, "cts_no_second_pop");
        chk("cts_pending", 32'(wp1 - rp1), 32'd1);
        cts1 = 1'b0;
        expect_frame(1, f1, 1, a);

        // Reset during data bit 3
        no_rd_for(1, 5, "pre_abort_idle");
        g0 = 8'($urandom);
        g1 = 8'($urandom);
        push1(g0);
        push1(g1);
        wait_rd(1, 300, a);
        if (a >= 0) begin
            repeat (19) @(negedge clk);
            chk("bit3_tx", tx1, g0[3]);
            reset = 1'b1;
            @(negedge clk);
            chk("abort_tx", tx1, 1'b1);
            chk("abort_busy", busy1, 1'b0);
            chk("abort_rd", rd1, 1'b0);
            reset = 1'b0;
            expect_frame(1, g1, 1, a);
            chk("abort_empty", 32'(wp1 - rp1), 32'd0);
        end

        // Two stop bits, 0x55 then a random byte
        h = 8'($urandom);
        push2(8'h55);
        push2(h);
        expect_frame(2, 8'h55, 2, a);
        expect_frame(2, h, 2, bb);
        chk("stop2_gap", 32'(bb - a), 32'd47);
        chk("stop2_empty", 32'(wp2 - rp2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
